// File: rtl/t05_cb_walker.sv
// Huffman codebook walker: depth-first traversal of the htree SRAM,
// one (symbol, code, length) per leaf on a valid/ready stream.
module t05_cb_walker #(
    parameter int IDX_W   = 8,
    parameter int MAX_LEN = 64,
    localparam int CH_W   = IDX_W + 1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IDX_W-1:0]    root_idx,
    output logic                mem_req,
    output logic [IDX_W-1:0]    mem_addr,
    input  logic                mem_rvalid,
    input  logic [2*CH_W-1:0]   mem_rdata,
    output logic                cw_valid,
    input  logic                cw_ready,
    output logic [IDX_W-1:0]    cw_symbol,
    output logic [MAX_LEN-1:0]  cw_code,
    output logic [LEN_W-1:0]    cw_len,
    output logic [IDX_W:0]      sym_count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SP_W = $clog2(MAX_LEN + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CH_W-1:0] NULL_CH = {2'b11, {(IDX_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_EVAL, S_EMIT, S_POP, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] c_q, c_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]   sym_q, sym_d;
    logic [CH_W-1:0]    l_q, l_d;
    logic [CH_W-1:0]    r_q, r_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic [SP_W-1:0]    sp_q, sp_d;

    logic [CH_W-1:0]    stk_ch_q [MAX_LEN];
    logic [LEN_W-1:0]   stk_d_q  [MAX_LEN];
    logic               push;
    logic [SP_W-1:0]    sp_m1;
    logic [CH_W-1:0]    top_ch;
    logic [LEN_W-1:0]   top_d;
    logic [LEN_W:0]     sh;
    logic [MAX_LEN-1:0] c_shr;
    logic [MAX_LEN-1:0] c_pop;
    logic [MAX_LEN-1:0] c_left;

    assign sp_m1  = sp_q - 1'b1;
    assign top_ch = stk_ch_q[sp_m1[AW-1:0]];
    assign top_d  = stk_d_q[sp_m1[AW-1:0]];
    // Drop the bits below the popped level, then take the right branch.
    assign sh     = {1'b0, n_q} - {1'b0, top_d} + 1'b1;
    assign c_shr  = c_q >> sh;
    assign c_pop  = {c_shr[MAX_LEN-2:0], 1'b1};
    assign c_left = {c_q[MAX_LEN-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            sym_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            sym_q   <= sym_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stk_ch_q[sp_q[AW-1:0]] <= r_q;
            stk_d_q[sp_q[AW-1:0]]  <= n_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        addr_d  = addr_q;
        sym_d   = sym_q;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    c_d     = '0;
                    n_d     = '0;
                    cnt_d   = '0;
                    sp_d    = '0;
                    addr_d  = root_idx;
                    state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    l_d     = mem_rdata[2*CH_W-1:CH_W];
                    r_d     = mem_rdata[CH_W-1:0];
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (l_q == NULL_CH && r_q == NULL_CH) begin
                    state_d = S_DONE;
                end else if (n_q == LEN_W'(MAX_LEN)) begin
                    sp_d    = '0;
                    state_d = S_ERR;
                end else begin
                    if (r_q != NULL_CH) begin
                        push = 1'b1;
                        sp_d = sp_q + 1'b1;
                    end
                    if (l_q == NULL_CH) begin
                        state_d = S_POP;
                    end else if (!l_q[CH_W-1]) begin
                        sym_d   = l_q[IDX_W-1:0];
                        c_d     = c_left;
                        n_d     = n_q + 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        c_d     = c_left;
                        n_d     = n_q + 1'b1;
                        addr_d  = l_q[IDX_W-1:0];
                        state_d = S_REQ;
                    end
                end
            end
            S_EMIT: begin
                if (cw_ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    sp_d = sp_m1;
                    c_d  = c_pop;
                    n_d  = top_d;
                    if (!top_ch[CH_W-1]) begin
                        sym_d   = top_ch[IDX_W-1:0];
                        state_d = S_EMIT;
                    end else begin
                        addr_d  = top_ch[IDX_W-1:0];
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = addr_q;
    assign cw_valid  = (state_q == S_EMIT);
    assign cw_symbol = sym_q;
    assign cw_code   = c_q;
    assign cw_len    = n_q;
    assign sym_count = cnt_q;
    assign busy      = state_q inside {S_REQ, S_WAIT, S_EVAL, S_EMIT, S_POP};
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_t05_cb_walker.sv
// Scoreboard bench for t05_cb_walker: directed trees, stalls,
// overflow on a MAX_LEN=2 instance and reset mid-walk.
module tb_t05_cb_walker;

    typedef struct packed {
        logic [7:0]  sym;
        logic [63:0] code;
        logic [6:0]  len;
    } cw_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [7:0]  root1, root2;
    logic        req1, req2;
    logic [7:0]  addr1, addr2;
    logic        mem_rvalid = 1'b0;
    logic [17:0] mem_rdata = '0;
    logic        v1, rdy1;
    logic [7:0]  sym1;
    logic [63:0] code1;
    logic [6:0]  len1;
    logic [8:0]  cnt1;
    logic        busy1, done1, err1;
    logic        v2;
    logic        rdy2;
    logic [7:0]  sym2;
    logic [1:0]  code2;
    logic [1:0]  len2;
    logic [8:0]  cnt2;
    logic        busy2, done2, err2;

    logic [17:0] mem [256];
    int          lat = 1;
    int          pend_cnt = 0;
    logic [7:0]  pend_addr = '0;
    int          nreq = 0;
    bit          sel = 1'b0;
    bit          stall = 1'b0;
    bit          emitted2 = 1'b0;
    int          nvec = 0;
    int          nfail = 0;
    cw_t         q[$];

    always #5 clk = ~clk;

    t05_cb_walker u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .root_idx(root1),
        .mem_req(req1), .mem_addr(addr1), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .cw_valid(v1), .cw_ready(rdy1),
        .cw_symbol(sym1), .cw_code(code1), .cw_len(len1),
        .sym_count(cnt1), .busy(busy1), .done(done1), .err(err1)
    );

    t05_cb_walker #(.IDX_W(8), .MAX_LEN(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .root_idx(root2),
        .mem_req(req2), .mem_addr(addr2), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .cw_valid(v2), .cw_ready(rdy2),
        .cw_symbol(sym2), .cw_code(code2), .cw_len(len2),
        .sym_count(cnt2), .busy(busy2), .done(done2), .err(err2)
    );

    // htree SRAM model with programmable read latency
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[pend_addr];
            end
        end
        if (sel ? req2 : req1) begin
            pend_addr <= sel ? addr2 : addr1;
            pend_cnt  <= lat;
            nreq      <= nreq + 1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int scnt;
        scnt = 0;
        rdy1 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!stall) begin
                rdy1 = 1'b1;
                scnt = 0;
            end else if (v1 && !rdy1) begin
                scnt++;
                if (scnt >= 5) rdy1 = 1'b1;
            end else begin
                rdy1 = 1'b0;
                scnt = 0;
            end
        end
    end

    initial begin
        cw_t cur, last, ex;
        bit  held;
        held = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (v2) emitted2 = 1'b1;
            if (!rst_n) begin
                held = 1'b0;
            end else if (v1) begin
                cur = {sym1, code1, len1};
                if (held) chk("stall_stable", cur, last);
                if (rdy1) begin
                    if (q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_cw: got %0h expected none", cur);
                    end else begin
                        ex = q.pop_front();
                        chk("cw", cur, ex);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    last = cur;
                end
            end
        end
    end

    task automatic exp_tree1();
        q.push_back({8'h41, 64'h0, 7'd2});
        q.push_back({8'h42, 64'h1, 7'd2});
        q.push_back({8'h43, 64'h1, 7'd1});
    endtask

    task automatic do_start(input bit d2, input logic [7:0] r);
        @(negedge clk);
        if (d2) begin
            start2 = 1'b1;
            root2  = r;
        end else begin
            start1 = 1'b1;
            root1  = r;
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        chk("start_lat", d2 ? req2 : req1, 1'b1);
    endtask

    task automatic wait_fin(input bit d2);
        int k;
        k = 0;
        while (!(d2 ? (done2 || err2) : (done1 || err1)) && k < 500) begin
            @(negedge clk);
            k++;
        end
        nvec++;
        if (k >= 500) begin
            nfail++;
            $display("FAIL walk_timeout: got busy expected done/err");
        end
    endtask

    task automatic chk_reset();
        chk("rst_u1", {v1, req1, busy1, done1, err1, cnt1, sym1,
                       code1, len1, addr1}, '0);
        chk("rst_u2", {v2, req2, busy2, done2, err2, cnt2}, '0);
    endtask

    initial begin
        int base;
        int k;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        root1  = '0;
        root2  = '0;
        rdy2   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[2]  = {9'h101, 9'h043};
        mem[1]  = {9'h041, 9'h042};
        mem[5]  = {9'h041, 9'h180};
        mem[6]  = {9'h180, 9'h180};
        mem[10] = {9'h10b, 9'h041};
        mem[11] = {9'h10c, 9'h042};
        mem[12] = {9'h043, 9'h044};
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;

        // balanced three-leaf tree
        base = nreq;
        exp_tree1();
        do_start(1'b0, 8'd2);
        wait_fin(1'b0);
        chk("t1_flags", {done1, err1, busy1}, 3'b100);
        chk("t1_count", cnt1, 9'd3);
        chk("t1_drain", q.size(), 0);
        chk("t1_reads", nreq - base, 2);

        // single leaf: code 0, len 1, one read only
        base = nreq;
        q.push_back({8'h41, 64'h0, 7'd1});
        do_start(1'b0, 8'd5);
        k = 0;
        while (!mem_rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rv_to_cw", v1, 1'b1);
        wait_fin(1'b0);
        chk("t2_count", cnt1, 9'd1);
        chk("t2_reads", nreq - base, 1);
        chk("t2_drain", q.size(), 0);

        // empty tree
        base = nreq;
        do_start(1'b0, 8'd6);
        wait_fin(1'b0);
        chk("t3_flags", {done1, err1}, 2'b10);
        chk("t3_count", cnt1, 9'd0);
        chk("t3_reads", nreq - base, 1);

        // back-pressure, plus a start pulse while busy
        stall = 1'b1;
        exp_tree1();
        do_start(1'b0, 8'd2);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        root1  = 8'd6;
        @(negedge clk);
        start1 = 1'b0;
        wait_fin(1'b0);
        chk("t4_count", cnt1, 9'd3);
        chk("t4_drain", q.size(), 0);
        stall = 1'b0;

        // overflow on MAX_LEN=2 instance
        sel = 1'b1;
        do_start(1'b1, 8'd10);
        wait_fin(1'b1);
        chk("t5_flags", {err2, done2, busy2}, 3'b100);
        chk("t5_count", cnt2, 9'd0);
        chk("t5_emit", emitted2, 1'b0);
        sel = 1'b0;

        // reset while waiting on a slow read, then a full restart
        lat = 3;
        do_start(1'b0, 8'd2);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_wait", busy1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle", {busy1, v1, done1}, 3'b000);
        exp_tree1();
        do_start(1'b0, 8'd2);
        wait_fin(1'b0);
        chk("t6_flags", {done1, err1}, 2'b10);
        chk("t6_count", cnt1, 9'd3);
        chk("t6_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
